ternary_triad_assembler: RTL and testbench

- Upstream feeder for the Peircean sign classifier.
- Accepts a serial stream of 2-bit trits on a valid/ready handshake and groups them into (I, II, III) triads.
- Presents each complete triad, with a fault flag, on a registered valid/ready output.
- Keeps saturating counters for discarded partial triads and faulted triads.

---
 rtl/ternary_triad_assembler.sv | 119 +++++++++++
 tb/tb_ternary_triad_assembler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ternary_triad_assembler.sv
// Groups a serial trit stream into (I, II, III) triads for the sign classifier.
// Tracks discarded partial triads and faulted triads in saturating counters.
module ternary_triad_assembler #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_trit,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_trich_i,
    output logic [1:0]       out_trich_ii,
    output logic [1:0]       out_trich_iii,
    output logic             out_fault,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] fault_count
);

    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    localparam logic [1:0] TRIT_ZERO  = 2'b01;
    localparam logic [1:0] TRIT_FAULT = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] phase;
    logic [1:0] trit_i;
    logic [1:0] trit_ii;

    logic accept;
    logic pop;
    logic load;
    logic drop;
    logic new_fault;

    // Only a completing trit can be blocked, and only by a held triad.
    assign in_ready  = !(phase == P2 && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign load      = accept && !in_sof && phase == P2;
    assign drop      = accept && in_sof && phase != P0;
    assign new_fault = (trit_i == TRIT_FAULT) || (trit_ii == TRIT_FAULT)
                     || (in_trit == TRIT_FAULT);

    // Phase tracking and capture of the first two trits of a triad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= P0;
            trit_i  <= TRIT_ZERO;
            trit_ii <= TRIT_ZERO;
        end else if (accept) begin
            if (in_sof) begin
                trit_i <= in_trit;
                phase  <= P1;
            end else begin
                case (phase)
                    P0: begin
                        trit_i <= in_trit;
                        phase  <= P1;
                    end
                    P1: begin
                        trit_ii <= in_trit;
                        phase   <= P2;
                    end
                    default: phase <= P0;
                endcase
            end
        end
    end

    // Output triad register; a same-cycle load wins over a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_trich_i   <= TRIT_ZERO;
            out_trich_ii  <= TRIT_ZERO;
            out_trich_iii <= TRIT_ZERO;
            out_fault     <= 1'b0;
        end else if (load) begin
            out_valid     <= 1'b1;
            out_trich_i   <= trit_i;
            out_trich_ii  <= trit_ii;
            out_trich_iii <= in_trit;
            out_fault     <= new_fault;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of partial triads discarded by a resync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (clr_cnt) begin
            drop_count <= '0;
        end else if (drop && drop_count != CNT_MAX) begin
            drop_count <= drop_count + CNT_ONE;
        end
    end

    // Saturating count of triads loaded with a fault trit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_count <= '0;
        end else if (clr_cnt) begin
            fault_count <= '0;
        end else if (load && new_fault && fault_count != CNT_MAX) begin
            fault_count <= fault_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ternary_triad_assembler.sv
// Directed bench for the triad assembler, built with 2-bit counters
// so that saturation is reachable in a few triads.
module tb_ternary_triad_assembler;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_trit;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_trich_i;
    logic [1:0]       out_trich_ii;
    logic [1:0]       out_trich_iii;
    logic             out_fault;
    logic             clr_cnt;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] fault_count;

    int checks = 0;
    int errors = 0;

    ternary_triad_assembler #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_trit      (in_trit),
        .in_sof       (in_sof),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_trich_i  (out_trich_i),
        .out_trich_ii (out_trich_ii),
        .out_trich_iii(out_trich_iii),
        .out_fault    (out_fault),
        .clr_cnt      (clr_cnt),
        .drop_count   (drop_count),
        .fault_count  (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_triad(input string tag, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] c,
                               input logic f);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"},
              {25'd0, out_trich_i, out_trich_ii, out_trich_iii, out_fault},
              {25'd0, a, b, c, f});
    endtask

    task automatic put(input logic sof, input logic [1:0] trit);
        in_valid = 1'b1;
        in_sof   = sof;
        in_trit  = trit;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] stream [9];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_trit   = 2'b00;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",
              {25'd0, out_trich_i, out_trich_ii, out_trich_iii, out_fault},
              {25'd0, 2'b01, 2'b01, 2'b01, 1'b0});
        check("rst_counts", {28'd0, drop_count, fault_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // First triad, one-cycle latency to out_valid.
        put(1'b1, 2'b00);
        check("t1_rdy_a", {31'd0, in_ready}, 32'd1);
        put(1'b0, 2'b01);
        check("t1_rdy_b", {31'd0, in_ready}, 32'd1);
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        put(1'b0, 2'b10);
        check("t1_rdy_c", {31'd0, in_ready}, 32'd1);
        check_triad("t1", 2'b00, 2'b01, 2'b10, 1'b0);
        idle();
        check("t1_popped", {31'd0, out_valid}, 32'd0);

        // Three back-to-back triads at full rate.
        stream = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00,
                   2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 9; i++) begin
            put(i % 3 == 0, stream[i]);
            check("t2_rdy", {31'd0, in_ready}, 32'd1);
            if (i % 3 == 2)
                check_triad("t2", stream[i-2], stream[i-1], stream[i], 1'b0);
            else
                check("t2_gap", {31'd0, out_valid}, 32'd0);
        end
        check("t2_drop", {30'd0, drop_count}, 32'd0);
        idle();

        // Backpressure stalls the third trit; release gives pop+load.
        out_ready = 1'b0;
        put(1'b1, 2'b01);
        put(1'b0, 2'b00);
        put(1'b0, 2'b10);
        check_triad("t3_first", 2'b01, 2'b00, 2'b10, 1'b0);
        put(1'b1, 2'b10);
        check("t3_rdy_p1", {31'd0, in_ready}, 32'd1);
        put(1'b0, 2'b01);
        in_trit = 2'b00;
        in_sof  = 1'b0;
        #1;
        check("t3_stall", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check_triad("t3_held", 2'b01, 2'b00, 2'b10, 1'b0);
        out_ready = 1'b1;
        #1;
        check("t3_unstall", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        check_triad("t3_second", 2'b10, 2'b01, 2'b00, 1'b0);
        idle();
        check("t3_popped", {31'd0, out_valid}, 32'd0);

        // Resync mid-triad.
        put(1'b1, 2'b10);
        put(1'b0, 2'b01);
        put(1'b1, 2'b00);
        check("t4_drop", {30'd0, drop_count}, 32'd1);
        put(1'b0, 2'b00);
        check("t4_not_yet", {31'd0, out_valid}, 32'd0);
        put(1'b0, 2'b00);
        check_triad("t4", 2'b00, 2'b00, 2'b00, 1'b0);
        idle();

        // Faulted triads and fault counter saturation.
        for (int n = 1; n <= 5; n++) begin
            put(1'b1, 2'b10);
            put(1'b0, 2'b11);
            put(1'b0, 2'b00);
            check_triad("t5_fault", 2'b10, 2'b11, 2'b00, 1'b1);
            check("t5_fcnt", {30'd0, fault_count}, (n > 3) ? 32'd3 : n);
        end
        put(1'b1, 2'b11);
        put(1'b0, 2'b00);
        clr_cnt = 1'b1;
        put(1'b0, 2'b00);
        clr_cnt = 1'b0;
        check_triad("t5_clr", 2'b11, 2'b00, 2'b00, 1'b1);
        check("t5_clr_cnts", {28'd0, drop_count, fault_count}, 32'd0);

        // Async reset mid-triad while a triad is held.
        out_ready = 1'b0;
        put(1'b1, 2'b01);
        put(1'b0, 2'b01);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("t6_held", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async", {31'd0, out_valid}, 32'd0);
        check("t6_drop", {30'd0, drop_count}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        put(1'b0, 2'b10);
        put(1'b0, 2'b00);
        put(1'b0, 2'b01);
        check_triad("t6_after", 2'b10, 2'b00, 2'b01, 1'b0);
        check("t6_drop_end", {30'd0, drop_count}, 32'd0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
